// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared constants and writeback entry type for the LEGv8 register file
package legv8_pkg;

    localparam int N_DATA = 64;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [N_DATA-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - 2-write/1-read circular writeback FIFO with ordered dual push
module wb_fifo
    import legv8_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push0_valid,
    input  wb_entry_t                push0_data,
    input  logic                     push1_valid,
    input  wb_entry_t                push1_data,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] push1_idx;
    wb_entry_t     mem_q [DEPTH];

    // push1 lands right behind push0 when both are written in the same cycle
    always_comb begin
        push1_idx = push0_valid ? wr_q + AW'(1) : wr_q;
        wr_d      = wr_q + AW'(push0_valid) + AW'(push1_valid);
        rd_d      = rd_q + AW'(pop);
        count_d   = count_q + CW'(push0_valid) + CW'(push1_valid) - CW'(pop);
    end

    // pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // storage is never read while empty, so it carries no reset
    always_ff @(posedge clk) begin
        if (push0_valid) mem_q[wr_q] <= push0_data;
        if (push1_valid) mem_q[push1_idx] <= push1_data;
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - serialises ALU and load writebacks onto the regfile write port
module regfile_writer
    import legv8_pkg::*;
#(
    parameter int N     = N_DATA,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [REG_AW-1:0]       alu_wa,
    input  logic [N-1:0]            alu_wd,
    output logic                    alu_ready,
    input  logic                    mem_valid,
    input  logic [REG_AW-1:0]       mem_wa,
    input  logic [N-1:0]            mem_wd,
    output logic                    mem_ready,
    input  logic                    issue_valid,
    input  logic [REG_AW-1:0]       issue_wa,
    output logic [31:0]             pend,
    output logic                    we3,
    output logic [REG_AW-1:0]       wa3,
    output logic [N-1:0]            wd3,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LVL_ONE_FREE = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LVL_TWO_FREE = CW'(DEPTH - 2);

    logic [CW-1:0] fifo_count;
    wb_entry_t     fifo_head;
    wb_entry_t     mem_entry, alu_entry;
    logic          mem_push, alu_push, pop;
    wb_entry_t     last_q;
    logic [31:0]   pend_q, pend_d;

    // mem gets the last free slot; alu only takes it when mem is not competing
    assign mem_ready = (fifo_count <= LVL_ONE_FREE);
    assign alu_ready = (fifo_count <= LVL_TWO_FREE) ||
                       ((fifo_count == LVL_ONE_FREE) && !mem_valid);

    // XZR writes are acknowledged but never enter the FIFO
    assign mem_push  = mem_valid && mem_ready && (mem_wa != XZR);
    assign alu_push  = alu_valid && alu_ready && (alu_wa != XZR);
    assign mem_entry = '{wa: mem_wa, wd: mem_wd};
    assign alu_entry = '{wa: alu_wa, wd: alu_wd};
    assign pop       = (fifo_count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push0_valid (mem_push),
        .push0_data  (mem_entry),
        .push1_valid (alu_push),
        .push1_data  (alu_entry),
        .pop         (pop),
        .head        (fifo_head),
        .count       (fifo_count)
    );

    // remember the last committed entry so wa3/wd3 hold steady while empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= '0;
        end else if (pop) begin
            last_q <= fifo_head;
        end
    end

    assign we3   = pop;
    assign wa3   = pop ? fifo_head.wa : last_q.wa;
    assign wd3   = pop ? fifo_head.wd : last_q.wd;
    assign count = fifo_count;

    // scoreboard: commit clears, issue sets afterwards so a newer in-flight write wins
    always_comb begin
        pend_d = pend_q;
        if (we3) pend_d[wa3] = 1'b0;
        if (issue_valid && (issue_wa != XZR)) pend_d[issue_wa] = 1'b1;
        pend_d[XZR] = 1'b0;
    end

    // scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: tb/tb_regfile_writer.sv
// tb/tb_regfile_writer.sv - randomized self-checking bench for regfile_writer
module tb_regfile_writer;

    localparam int N     = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, mem_valid, issue_valid;
    logic [4:0]    alu_wa, mem_wa, issue_wa;
    logic [N-1:0]  alu_wd, mem_wd;
    logic          alu_ready, mem_ready, we3;
    logic [31:0]   pend;
    logic [4:0]    wa3;
    logic [N-1:0]  wd3;
    logic [$clog2(DEPTH):0] count;

    typedef struct {
        logic [4:0]   wa;
        logic [N-1:0] wd;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        last_e;
    logic [31:0] exp_pend;
    int          n_checks = 0;
    int          n_fail   = 0;

    regfile_writer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_wa      (alu_wa),
        .alu_wd      (alu_wd),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_wa      (mem_wa),
        .mem_wd      (mem_wd),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .pend        (pend),
        .we3         (we3),
        .wa3         (wa3),
        .wd3         (wd3),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_e   = '{wa: 5'd0, wd: '0};
        exp_pend = '0;
    endtask

    function automatic bit space_for(input int need);
        return (DEPTH - exp_q.size()) >= need;
    endfunction

    // compare every DUT output against the queue model for the current inputs
    task automatic check_all(output bit mr, output bit ar);
        int sz;
        sz = exp_q.size();
        mr = space_for(1);
        ar = space_for(2) || (space_for(1) && !mem_valid);
        check("mem_ready", 64'(mem_ready), 64'(mr));
        check("alu_ready", 64'(alu_ready), 64'(ar));
        check("we3", 64'(we3), 64'(sz != 0));
        check("wa3", 64'(wa3), 64'(sz != 0 ? exp_q[0].wa : last_e.wa));
        check("wd3", wd3, sz != 0 ? exp_q[0].wd : last_e.wd);
        check("count", 64'(count), 64'(sz));
        check("pend", 64'(pend), 64'(exp_pend));
    endtask

    task automatic cycle(input bit mv, input logic [4:0] mwa, input logic [63:0] mwd,
                         input bit av, input logic [4:0] awa, input logic [63:0] awd,
                         input bit iv, input logic [4:0] iwa);
        bit mr, ar;
        @(negedge clk);
        mem_valid = mv; mem_wa = mwa; mem_wd = mwd;
        alu_valid = av; alu_wa = awa; alu_wd = awd;
        issue_valid = iv; issue_wa = iwa;
        #1;
        check_all(mr, ar);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            last_e = exp_q.pop_front();
            exp_pend[last_e.wa] = 1'b0;
        end
        if (mv && mr && mwa != 5'd31) exp_q.push_back('{wa: mwa, wd: mwd});
        if (av && ar && awa != 5'd31) exp_q.push_back('{wa: awa, wd: awd});
        if (iv && iwa != 5'd31) exp_pend[iwa] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0);
    endtask

    initial begin
        bit mr, ar;
        reset = 1'b1;
        mem_valid = 0; mem_wa = 0; mem_wd = 0;
        alu_valid = 0; alu_wa = 0; alu_wd = 0;
        issue_valid = 0; issue_wa = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single ALU write and its commit
        cycle(0, 5'd0, 64'd0, 1, 5'd5, 64'hA5, 0, 5'd0);
        idle(3);

        // dual push ordering: mem ahead of alu
        cycle(1, 5'd3, 64'd30, 1, 5'd4, 64'd40, 0, 5'd0);
        idle(4);

        // backpressure with both producers held valid
        for (int i = 0; i < 10; i++)
            cycle(1, 5'(i % 8 + 8), 64'(100 + i), 1, 5'(i % 8 + 16), 64'(200 + i), 0, 5'd0);
        idle(6);

        // XZR drop on both paths and on issue
        cycle(1, 5'd31, 64'hDEAD, 1, 5'd31, 64'hBEEF, 1, 5'd31);
        idle(2);

        // scoreboard set, clear on commit, and set-wins collision
        cycle(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd7);
        cycle(0, 5'd0, 64'd0, 1, 5'd7, 64'h77, 0, 5'd0);
        cycle(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd7);
        idle(2);
        cycle(0, 5'd0, 64'd0, 1, 5'd7, 64'h78, 0, 5'd0);
        idle(3);

        // async reset with count=3 and pend=F0
        for (int i = 0; i < 4; i++)
            cycle(1, 5'd1, 64'(i), 1, 5'd2, 64'(i + 50), 1, 5'(4 + i));
        @(negedge clk);
        mem_valid = 1; alu_valid = 1; issue_valid = 0;
        #1;
        check("pre_reset_count", 64'(count), 64'd3);
        check("pre_reset_pend", 64'(pend), 64'h0000_00F0);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        mem_valid = 0; alu_valid = 0;
        #1;
        check_all(mr, ar);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                  ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                  ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 31)));
        end
        idle(DEPTH + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writer.md
Name: regfile_writer

Overview:
- Write-side front end of the 32x64 register file. It collects writeback results from two producers, the ALU path and the multi-cycle memory-load path.
- It serialises them into the regfile's single write port (we3/wa3/wd3), one write per cycle.
- It keeps a pending-destination scoreboard so decode can stall on in-flight destinations.
- Writes to register 31 (XZR) are absorbed and never reach the regfile.

Parameters:
N, 64, data width of a register
DEPTH, 4, writeback FIFO entries; power of 2, minimum 2

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high
alu_valid  input  1  ALU result offered
alu_wa  input  5  ALU destination register
alu_wd  input  N  ALU result data
alu_ready  output  1  ALU result accepted when alu_valid && alu_ready
mem_valid  input  1  load result offered
mem_wa  input  5  load destination register
mem_wd  input  N  load data
mem_ready  output  1  load result accepted when mem_valid && mem_ready
issue_valid  input  1  decode issued an instruction writing issue_wa
issue_wa  input  5  destination being issued
pend  output  32  bit r set = write to Xr in flight
we3  output  1  regfile write enable
wa3  output  5  regfile write address
wd3  output  N  regfile write data
count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, any time, including mid-drain):
  - FIFO empties: pointers 0, count 0.
  - pend = 0.
  - we3 = 0, wa3 = 0, wd3 = 0.
  - Ready outputs take their combinational values from count = 0: both 1.
- Ready rules (combinational from count and mem_valid only; never from pop):
  - mem_ready = count <= DEPTH-1.
  - alu_ready = count <= DEPTH-2, or (count == DEPTH-1 && !mem_valid).
- Push:
  - Up to two pushes per cycle.
  - On a simultaneous push, the mem entry is ordered ahead of the alu entry.
  - An accepted transfer with wa == 31 is acknowledged but not pushed: no FIFO entry, no we3, no pend change.
- Pop / commit:
  - we3/wa3/wd3 are driven from the FIFO head. we3 = (count != 0).
  - The regfile always accepts the write, so the head is popped every cycle in which count != 0.
  - Latency: a value accepted at edge t appears on the write port during cycle t+1 when the FIFO was empty before that edge, and is written into the regfile at edge t+1.
  - Behind k older entries, it appears k cycles later.
  - Throughput: one commit per cycle.
  - When count == 0, wa3/wd3 hold the last driven values; only we3 is qualified.
- Count update:
  - count_next = count + pushes - pop.
  - Push and pop in the same cycle at full (DEPTH) is impossible by the ready rules.
  - Push and pop in the same cycle at empty is legal; the pushed entry becomes head next cycle.
- Pointers wrap modulo DEPTH.
- Scoreboard:
  - pend[issue_wa] is set at the edge where issue_valid && issue_wa != 31.
  - pend[wa3] is cleared at the edge where we3 is high.
  - If the same register is set and cleared in one cycle, set wins: a newer write is still in flight.
  - pend[31] is constant 0.
  - Issuing an already-pending register is legal; pend stays 1 and is cleared by the first commit to it.
- No X propagation: FIFO storage needs no reset, but the head is never observed when count == 0.

Decomposition:
- Shared package (legv8_pkg):
  - XZR = 5'd31.
  - REG_AW = 5.
  - typedef struct packed {logic [4:0] wa; logic [N-1:0] wd;} wb_entry_t, parameterised via the package constant N_DATA = 64.
- One sub-module: wb_fifo. It is a 2-write/1-read circular FIFO with ordered dual push, and it exposes count and head.
- The scoreboard and ready logic stay in regfile_writer.

Test Plan:
- Reset then single ALU write: alu_valid=1, alu_wa=5, alu_wd=64'hA5 for 1 cycle -> next cycle we3=1, wa3=5, wd3=64'hA5; following cycle we3=0, count=0.
- Dual push ordering: mem(wa=3, wd=30) and alu(wa=4, wd=40) in the same cycle -> count=2; the next two cycles commit wa3=3/wd3=30, then wa3=4/wd3=40.
- Backpressure (DEPTH=4): hold both producers valid with distinct addresses -> count never exceeds 4. At count=3 with mem_valid=1, alu_ready=0 and mem_ready=1. No entry is lost or duplicated; commit order matches acceptance order.
- XZR drop: alu_wa=31, alu_valid=1 -> alu_ready=1, count stays 0, we3 stays 0; issue_valid with issue_wa=31 leaves pend=0.
- Scoreboard: issue_wa=7 -> pend[7]=1. Later the ALU writes wa=7 -> pend[7] clears at the commit edge. Issue wa=7 in the same cycle as that commit -> pend[7] remains 1.
- Async reset mid-operation: with count=3 and pend=32'h0000_00F0, assert reset between clock edges -> immediately we3=0, wa3=0, wd3=0, count=0, pend=0. After release, no stale commits occur.
